// File: rtl/univ_shiftreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the helper that sizes the shift counter.
package univ_shiftreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_SHIFT_R = 2'd1,
    MODE_SHIFT_L = 2'd2,
    MODE_LOAD    = 2'd3
  } mode_e;

  // Bits needed to hold a shift count from 0 up to width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shiftreg_bitcnt.sv
// shift_bitcnt: frame counter for the universal shift register. Counts shift
// edges, wraps at WIDTH-1 and emits a registered one-cycle done pulse on the
// WIDTH-th shift. clr restarts the frame; idle cycles leave cnt untouched.
module shift_bitcnt
  import univ_shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic                       clr,
  output logic [cnt_w(WIDTH)-1:0]    cnt,
  output logic                       done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Next count / done: done is a pulse, so it defaults low every cycle.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shiftreg.sv
// univ_shiftreg: universal shift register with hold, shift right, shift left
// and parallel load, plus a frame counter (shift_bitcnt) that pulses done
// after every WIDTH shifts in either direction.
// Optional build macro UNIV_SHIFTREG_ROTATE_EN adds input rot: when high,
// shifts recirculate the bit falling off the far end instead of sin_r/sin_l.
module univ_shiftreg
  import univ_shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
`ifdef UNIV_SHIFTREG_ROTATE_EN
  input  logic                       rot,
`endif
  input  logic [WIDTH-1:0]           pdata,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [cnt_w(WIDTH)-1:0]    cnt,
  output logic                       done
);

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic             fill_r, fill_l;
  logic             shift_en, load_en;

  assign mode_s = mode_e'(mode);

  // Bit entering each end of the register on a shift.
`ifdef UNIV_SHIFTREG_ROTATE_EN
  assign fill_r = rot ? q_q[0]       : sin_r;
  assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  // Next register contents selected by mode.
  always_comb begin
    q_d = q_q;
    unique case (mode_s)
      MODE_HOLD:    q_d = q_q;
      MODE_SHIFT_R: q_d = {fill_r, q_q[WIDTH-1:1]};
      MODE_SHIFT_L: q_d = {q_q[WIDTH-2:0], fill_l};
      MODE_LOAD:    q_d = pdata;
      default:      q_d = q_q;
    endcase
  end

  // Data register; asynchronous reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign shift_en = (mode_s == MODE_SHIFT_R) || (mode_s == MODE_SHIFT_L);
  assign load_en  = (mode_s == MODE_LOAD);

  shift_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (load_en),
    .cnt      (cnt),
    .done     (done)
  );

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule
